s1_serializer: RTL and testbench



---
 rtl/s1_serializer_if.sv | 28 ++
 rtl/s1_serializer.sv | 118 +++++++++++
 tb/tb_s1_serializer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s1_serializer_if.sv
// s1_serializer_if: RB1 read port plus the sen/sd serial link to S2.
//   RB1_RW  1 = read (serializer holds it at 1)
//   RB1_A   RB1 word address 0..17
//   RB1_D   RB1 write data (unused, 0)
//   RB1_Q   RB1 read data, one cycle after RB1_A
//   sen     serial enable, active-low while packet bits are on sd
//   sd      serial data, MSB first
//   S1_done sticky transfer-complete flag
// master = serializer side, slave = RB1 / S2 side.
interface s1_serializer_if;
  logic       RB1_RW;
  logic [4:0] RB1_A;
  logic [7:0] RB1_D;
  logic [7:0] RB1_Q;
  logic       sen;
  logic       sd;
  logic       S1_done;

  modport master (
    output RB1_RW, RB1_A, RB1_D, sen, sd, S1_done,
    input  RB1_Q
  );

  modport slave (
    input  RB1_RW, RB1_A, RB1_D, sen, sd, S1_done,
    output RB1_Q
  );
endinterface

// File: rtl/s1_serializer.sv
// s1_serializer: reads 18 x 8-bit words from RB1, transposes them into eight
// 18-bit columns and sends each column as a 21-bit packet {p[2:0], col} on
// sen/sd, MSB first, with one sen-high gap cycle after every packet.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset (aborts any transfer in progress)
//   bus  s1_serializer_if.master: RB1 read port, serial link, S1_done
module s1_serializer (
  input  logic               clk,
  input  logic               rst,
  s1_serializer_if.master    bus
);
  typedef enum logic [1:0] {READ, SEND, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [4:0]       addr_q, addr_d;    // RB1 address, saturates at 17
  logic [4:0]       cap_a_q, cap_a_d;  // address whose data is on RB1_Q now
  logic             cap_vld_q, cap_vld_d;
  logic [2:0]       pkt_q, pkt_d;      // packet index, stops at 7
  logic [4:0]       bit_q, bit_d;      // packet bit currently on sd
  logic             sen_q, sen_d;
  logic             sd_q, sd_d;
  logic             done_q, done_d;
  logic [17:0][7:0] rbuf;
  logic [20:0]      cur_pkt;

  // Packet for the current index: header in the top 3 bits, bit j = word j bit p.
  always_comb begin
    cur_pkt = '0;
    cur_pkt[20:18] = pkt_q;
    for (int j = 0; j < 18; j++) cur_pkt[j] = rbuf[j][pkt_q];
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cap_a_d   = cap_a_q;
    cap_vld_d = cap_vld_q;
    pkt_d     = pkt_q;
    bit_d     = bit_q;
    sen_d     = 1'b1;
    sd_d      = 1'b0;
    done_d    = done_q;
    case (state_q)
      READ: begin
        // RB1_Q lags RB1_A by one cycle, so remember which word is arriving.
        cap_vld_d = 1'b1;
        cap_a_d   = addr_q;
        if (addr_q != 5'd17) addr_d = addr_q + 5'd1;
        if (cap_vld_q && cap_a_q == 5'd17) begin
          // Word 17 lands this edge; bit 20 is header-only so it is safe to start.
          state_d = SEND;
          bit_d   = 5'd20;
          sen_d   = 1'b0;
          sd_d    = pkt_q[2];
        end
      end
      SEND: begin
        if (bit_q == 5'd0) begin
          state_d = GAP;
        end else begin
          bit_d = bit_q - 5'd1;
          sen_d = 1'b0;
          sd_d  = cur_pkt[bit_q - 5'd1];
        end
      end
      GAP: begin
        if (pkt_q == 3'd7) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          pkt_d   = pkt_q + 3'd1;
          state_d = SEND;
          bit_d   = 5'd20;
          sen_d   = 1'b0;
          sd_d    = pkt_d[2];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= READ;
      addr_q    <= '0;
      cap_a_q   <= '0;
      cap_vld_q <= 1'b0;
      pkt_q     <= '0;
      bit_q     <= '0;
      sen_q     <= 1'b1;
      sd_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cap_a_q   <= cap_a_d;
      cap_vld_q <= cap_vld_d;
      pkt_q     <= pkt_d;
      bit_q     <= bit_d;
      sen_q     <= sen_d;
      sd_q      <= sd_d;
      done_q    <= done_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (rst && state_q == READ && cap_vld_q) rbuf[cap_a_q] <= bus.RB1_Q;
  end

  assign bus.RB1_RW  = 1'b1;
  assign bus.RB1_A   = addr_q;
  assign bus.RB1_D   = 8'h00;
  assign bus.sen     = sen_q;
  assign bus.sd      = sd_q;
  assign bus.S1_done = done_q;
endmodule

// File: tb/tb_s1_serializer.sv
module tb_s1_serializer;
  localparam int NCYC = 210;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  s1_serializer_if ifc ();
  s1_serializer dut (.clk(clk), .rst(rst), .bus(ifc.master));

  // RB1 model: one-cycle registered read.
  int         words [18];
  logic [7:0] rb1_q = 8'h00;
  always @(posedge clk) rb1_q <= (ifc.RB1_A < 5'd18) ? 8'(words[ifc.RB1_A]) : 8'h00;
  assign ifc.RB1_Q = rb1_q;

  int checks = 0;
  int errors = 0;

  // Per-cycle log of a run, cycle 0 = first cycle after rst rises.
  logic       sen_l [NCYC];
  logic       sd_l  [NCYC];
  logic       done_l[NCYC];
  logic       rw_l  [NCYC];
  logic [4:0] a_l   [NCYC];
  logic [7:0] d_l   [NCYC];

  // Parsed packets.
  int          npkt;
  logic [20:0] pkt_val  [16];
  int          pkt_len  [16];
  int          pkt_start[16];
  int          gap_len  [16];

  // Reference: packet p = {p, column p of the 18x8 word matrix}.
  function automatic logic [20:0] exp_pkt(int p);
    logic [17:0] col;
    col = '0;
    for (int j = 0; j < 18; j++) col[j] = 1'((words[j] >> p) & 1);
    return {3'(p), col};
  endfunction

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic capture();
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      sen_l[c] = ifc.sen; sd_l[c] = ifc.sd; done_l[c] = ifc.S1_done;
      rw_l[c] = ifc.RB1_RW; a_l[c] = ifc.RB1_A; d_l[c] = ifc.RB1_D;
    end
  endtask

  task automatic parse();
    npkt = 0;
    for (int i = 0; i < 16; i++) begin
      pkt_val[i] = '0; pkt_len[i] = 0; pkt_start[i] = -1; gap_len[i] = 0;
    end
    for (int c = 0; c < NCYC; c++) begin
      if (sen_l[c] === 1'b0) begin
        if ((c == 0 || sen_l[c-1] !== 1'b0) && npkt < 16) begin
          pkt_start[npkt] = c;
          npkt++;
        end
        if (npkt > 0) begin
          pkt_val[npkt-1] = {pkt_val[npkt-1][19:0], sd_l[c]};
          pkt_len[npkt-1]++;
        end
      end else if (npkt > 0) begin
        gap_len[npkt-1]++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ifc.RB1_RW !== 1'b1 || ifc.RB1_A !== 5'd0 || ifc.RB1_D !== 8'h00 ||
          ifc.sen !== 1'b1 || ifc.sd !== 1'b0 || ifc.S1_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_values cyc%0d: rw=%b a=%0d d=%h sen=%b sd=%b done=%b, want 1 0 00 1 0 0",
                 c, ifc.RB1_RW, ifc.RB1_A, ifc.RB1_D, ifc.sen, ifc.sd, ifc.S1_done);
      end
    end
  endtask

  task automatic test_all_ones();
    for (int j = 0; j < 18; j++) words[j] = 8'hFF;
    do_reset(3);
    capture();
    parse();
    checks++;
    if (pkt_val[0] !== {3'd0, 18'h3FFFF}) begin
      errors++; $display("FAIL ones_pkt0: got %h want %h", pkt_val[0], {3'd0, 18'h3FFFF});
    end
    checks++;
    if (pkt_val[7] !== {3'd7, 18'h3FFFF}) begin
      errors++; $display("FAIL ones_pkt7: got %h want %h", pkt_val[7], {3'd7, 18'h3FFFF});
    end
    checks++;
    if (done_l[194] !== 1'b0 || done_l[195] !== 1'b1) begin
      errors++; $display("FAIL ones_done_cycle: done@194=%b done@195=%b want 0 1", done_l[194], done_l[195]);
    end
  endtask

  task automatic test_index_pattern();
    for (int j = 0; j < 18; j++) words[j] = j;
    do_reset(2);
    capture();
    parse();
    checks++;
    if (npkt !== 8) begin
      errors++; $display("FAIL index_npkt: got %0d want 8", npkt);
    end
    checks++;
    if (pkt_val[0][17:0] !== 18'h2AAAA) begin
      errors++; $display("FAIL index_pkt0_data: got %h want 2aaaa", pkt_val[0][17:0]);
    end
    checks++;
    if (pkt_val[1][17:0] !== 18'h0CCCC) begin
      errors++; $display("FAIL index_pkt1_data: got %h want 0cccc", pkt_val[1][17:0]);
    end
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (pkt_val[p] !== exp_pkt(p)) begin
        errors++; $display("FAIL index_pkt%0d: got %h want %h", p, pkt_val[p], exp_pkt(p));
      end
      checks++;
      if (pkt_val[p][20:18] !== 3'(p)) begin
        errors++; $display("FAIL index_addr%0d: got %0d want %0d", p, pkt_val[p][20:18], p);
      end
    end
  endtask

  task automatic test_framing();
    for (int t = 0; t < 3; t++) begin
      int bad_a, bad_rw, first_done, done_drop, late_low;
      for (int j = 0; j < 18; j++) words[j] = $urandom_range(0, 255);
      do_reset(1 + t);
      capture();
      parse();
      checks++;
      if (npkt !== 8) begin
        errors++; $display("FAIL frame_npkt t%0d: got %0d want 8", t, npkt);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (pkt_len[i] !== 21 || pkt_start[i] !== 19 + 22 * i) begin
          errors++; $display("FAIL frame_pkt%0d t%0d: len=%0d start=%0d want 21 %0d",
                             i, t, pkt_len[i], pkt_start[i], 19 + 22 * i);
        end
        if (i < 7) begin
          checks++;
          if (gap_len[i] !== 1) begin
            errors++; $display("FAIL frame_gap%0d t%0d: got %0d want 1", i, t, gap_len[i]);
          end
        end
        checks++;
        if (pkt_val[i] !== exp_pkt(i)) begin
          errors++; $display("FAIL frame_data%0d t%0d: got %h want %h", i, t, pkt_val[i], exp_pkt(i));
        end
      end
      bad_a = 0; bad_rw = 0; first_done = -1; done_drop = 0; late_low = 0;
      for (int c = 0; c < NCYC; c++) begin
        if (c <= 17 && a_l[c] !== 5'(c)) bad_a++;
        if (rw_l[c] !== 1'b1 || d_l[c] !== 8'h00) bad_rw++;
        if (first_done < 0 && done_l[c] === 1'b1) first_done = c;
        if (first_done >= 0 && done_l[c] !== 1'b1) done_drop++;
        if (c >= 195 && sen_l[c] !== 1'b1) late_low++;
      end
      checks++;
      if (bad_a !== 0) begin
        errors++; $display("FAIL frame_addr_seq t%0d: %0d cycles with RB1_A != cycle index", t, bad_a);
      end
      checks++;
      if (bad_rw !== 0) begin
        errors++; $display("FAIL frame_rw t%0d: %0d cycles with RB1_RW!=1 or RB1_D!=0", t, bad_rw);
      end
      checks++;
      if (first_done !== 195 || done_drop !== 0 || late_low !== 0) begin
        errors++; $display("FAIL frame_done t%0d: first=%0d drops=%0d sen_low_after=%0d want 195 0 0",
                           t, first_done, done_drop, late_low);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    logic [20:0] old_p3;
    for (int j = 0; j < 18; j++) words[j] = $urandom_range(0, 255);
    old_p3 = exp_pkt(3);
    do_reset(2);
    // Packet 3 starts at cycle 85; bit 10 is on sd at cycle 95.
    for (int c = 0; c <= 95; c++) @(negedge clk);
    checks++;
    if (ifc.sen !== 1'b0 || ifc.sd !== old_p3[10]) begin
      errors++; $display("FAIL midrst_bit10: sen=%b sd=%b want 0 %b", ifc.sen, ifc.sd, old_p3[10]);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ifc.sen !== 1'b1 || ifc.S1_done !== 1'b0 || ifc.RB1_A !== 5'd0 || ifc.sd !== 1'b0) begin
      errors++; $display("FAIL midrst_abort: sen=%b done=%b a=%0d sd=%b want 1 0 0 0",
                         ifc.sen, ifc.S1_done, ifc.RB1_A, ifc.sd);
    end
    for (int j = 0; j < 18; j++) words[j] = $urandom_range(0, 255);
    @(posedge clk);
    #1 rst = 1'b1;
    capture();
    parse();
    checks++;
    if (a_l[0] !== 5'd0 || a_l[5] !== 5'd5 || a_l[17] !== 5'd17) begin
      errors++; $display("FAIL midrst_readrestart: a0=%0d a5=%0d a17=%0d want 0 5 17", a_l[0], a_l[5], a_l[17]);
    end
    checks++;
    if (npkt !== 8 || pkt_start[0] !== 19 || pkt_val[0] !== exp_pkt(0)) begin
      errors++; $display("FAIL midrst_pkt0: npkt=%0d start=%0d val=%h want 8 19 %h",
                         npkt, pkt_start[0], pkt_val[0], exp_pkt(0));
    end
    checks++;
    if (pkt_val[3] !== exp_pkt(3) || pkt_len[3] !== 21) begin
      errors++; $display("FAIL midrst_pkt3: val=%h len=%0d want %h 21", pkt_val[3], pkt_len[3], exp_pkt(3));
    end
  endtask

  task automatic test_end_to_end();
    logic [20:0] sh;
    logic [17:0] rb2 [8];
    int rows, nb, bad_addr;
    for (int j = 0; j < 18; j++) words[j] = 8'hA5 ^ j;
    do_reset(3);
    capture();
    // S2 collector: shift while sen low, commit a row on the first high cycle.
    rows = 0; nb = 0; sh = '0; bad_addr = 0;
    for (int p = 0; p < 8; p++) rb2[p] = '0;
    for (int c = 0; c < NCYC; c++) begin
      if (sen_l[c] === 1'b0) begin
        sh = {sh[19:0], sd_l[c]};
        nb++;
      end else if (nb != 0) begin
        if (nb == 21 && rows < 8) begin
          if (sh[20:18] !== 3'(rows)) bad_addr++;
          rb2[rows] = sh[17:0];
          rows++;
        end
        nb = 0;
      end
    end
    for (int p = 0; p < 8; p++) begin
      logic [20:0] e;
      e = exp_pkt(p);
      checks++;
      if (rb2[p] !== e[17:0]) begin
        errors++; $display("FAIL e2e_rb2[%0d]: got %h want %h", p, rb2[p], e[17:0]);
      end
    end
    checks++;
    if (bad_addr !== 0) begin
      errors++; $display("FAIL e2e_addr: %0d packets with address != arrival index", bad_addr);
    end
    checks++;
    if (rows !== 8 || done_l[NCYC-1] !== 1'b1) begin
      errors++; $display("FAIL e2e_done: s2_rows=%0d s1_done=%b want 8 1", rows, done_l[NCYC-1]);
    end
  endtask

  initial begin
    for (int j = 0; j < 18; j++) words[j] = 0;
    test_reset();
    test_all_ones();
    test_index_pattern();
    test_framing();
    test_reset_mid_send();
    test_end_to_end();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
